// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the fetch-side sequencing logic.
//   next_sel_e : encoding of the next-pc source chosen each cycle
//   PC_STEP    : byte distance between consecutive instruction words
package cpu_pkg;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    SEL_PLUS4,   // sequential fetch
    SEL_BRANCH,  // taken conditional branch
    SEL_JUMP,    // j / jal pseudo-direct target
    SEL_REG,     // jr, or ret with an empty return stack
    SEL_RAS,     // ret served from the return stack
    SEL_HOLD     // stall: keep the current pc
  } next_sel_e;

endpackage : cpu_pkg

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control/target inputs and pc/RAS status outputs of the
// pc sequencer. The clock and reset travel as plain ports, not through here.
//   master : decode/execute side, drives control, observes pc and RAS status
//   slave  : pc_sequencer
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             stall;
  logic             branch_eq;
  logic             branch_ne;
  logic             zero;
  logic             jump;
  logic             jal;
  logic             jr;
  logic             ret;
  logic [WIDTH-1:0] jr_target;
  logic [15:0]      imm16;
  logic [25:0]      imm26;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             ras_empty;
  logic             ras_full;
  logic [1:0]       ras_err;

  modport master (
    output stall, branch_eq, branch_ne, zero, jump, jal, jr, ret,
           jr_target, imm16, imm26,
    input  pc, pc_plus4, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch_eq, branch_ne, zero, jump, jal, jr, ret,
           jr_target, imm16, imm26,
    output pc, pc_plus4, ras_empty, ras_full, ras_err
  );

endinterface : pc_sequencer_if

// File: rtl/ras_stack.sv
// ras_stack -- circular return-address stack.
//   clk, rst  : clock, synchronous active-high reset (pointer/count only)
//   push      : write push_data as the new top
//   pop       : discard the top (ignored while empty)
//   push+pop  : top replaced in place by push_data, count unchanged
//   top       : current top entry (undefined while empty)
//   count     : number of valid entries, 0..DEPTH
//   empty/full: decoded from the registered count
//   overflow  : push without pop while full; the oldest entry is overwritten
module ras_stack #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;      // next free slot; top lives at ptr-1
  logic [PW-1:0]    top_idx;
  logic             do_pop;

  // DEPTH is a power of two, so pointer arithmetic wraps for free and a
  // push onto a full stack lands on the oldest entry.
  assign top_idx  = ptr - 1'b1;
  assign top      = mem[top_idx];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign overflow = push && !do_pop && full;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          ptr <= ptr + 1'b1;
          if (!full) count <= count + 1'b1;
        end
        2'b01: begin
          ptr   <= top_idx;
          count <= count - 1'b1;
        end
        default: ;  // idle, or pop-then-push leaves pointer and count alone
      endcase
    end
  end

  // NOTE: entries are deliberately left out of reset; count gates their
  // validity, and a reset-free array maps onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[do_pop ? top_idx : ptr] <= push_data;
  end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with branch/jump/jr targets and a
// return-address stack for jal/ret.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_sequencer_if.slave -- control inputs (stall, branch_eq,
//              branch_ne, zero, jump, jal, jr, ret, jr_target, imm16, imm26)
//              and outputs (pc, pc_plus4, ras_empty, ras_full,
//              ras_err = sticky {underflow, overflow})
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;
  logic             ras_empty, ras_full, ras_overflow;
  logic             taken;
  logic             ras_cmd_ok;
  logic             ras_push, ras_pop, ras_underflow;
  logic [1:0]       err_q;
  next_sel_e        sel;

  assign pc_plus4   = pc_q + WIDTH'(PC_STEP);
  assign taken      = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);
  assign br_target  = pc_plus4 + {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jmp_target = {pc_plus4[WIDTH-1:28], bus.imm26, 2'b00};

  // jr and stall suppress all stack traffic; jal pushes even when a higher
  // priority redirect (ret, taken branch) decides the pc.
  assign ras_cmd_ok    = ~bus.stall & ~bus.jr;
  assign ras_push      = bus.jal & ras_cmd_ok;
  assign ras_pop       = bus.ret & ras_cmd_ok & (ras_count != '0);
  assign ras_underflow = bus.ret & ras_cmd_ok & (ras_count == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns sel; no latch is inferred.
    sel = SEL_PLUS4;
    if (bus.stall)                     sel = SEL_HOLD;
    else if (bus.jr)                   sel = SEL_REG;
    else if (bus.ret)                  sel = ras_empty ? SEL_REG : SEL_RAS;
    else if (taken)                    sel = SEL_BRANCH;
    else if (bus.jump || bus.jal)      sel = SEL_JUMP;
  end

  always_comb begin
    pc_next = pc_plus4;
    unique case (sel)
      SEL_HOLD:   pc_next = pc_q;
      SEL_REG:    pc_next = bus.jr_target;
      SEL_RAS:    pc_next = ras_top;
      SEL_BRANCH: pc_next = br_target;
      SEL_JUMP:   pc_next = jmp_target;
      default:    pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= '0;
    end else begin
      pc_q  <= pc_next;
      err_q <= err_q | {ras_underflow, ras_overflow};
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = err_q;

endmodule : pc_sequencer

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits; legal range 32..64.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold PC and RAS this cycle.
REQ-007 SHALL have port branch_eq  input  1  BEQ in execute.
REQ-008 SHALL have port branch_ne  input  1  BNE in execute.
REQ-009 SHALL have port zero  input  1  ALU zero flag.
REQ-010 SHALL have port jump  input  1  J instruction.
REQ-011 SHALL have port jal  input  1  JAL instruction: jump and push return address.
REQ-012 SHALL have port jr  input  1  JR instruction: jump to jr_target.
REQ-013 SHALL have port ret  input  1  return: pop RAS, jump to popped entry.
REQ-014 SHALL have port jr_target  input  WIDTH  register-file operand for jr/ret fallback.
REQ-015 SHALL have port imm16  input  16  branch offset in words, signed.
REQ-016 SHALL have port imm26  input  26  jump index in words.
REQ-017 SHALL have port pc  output  WIDTH  current PC, registered.
REQ-018 SHALL have port pc_plus4  output  WIDTH  pc+4, combinational.
REQ-019 SHALL have port ras_empty  output  1  RAS holds 0 entries.
REQ-020 SHALL have port ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-021 SHALL have port ras_err  output  2  sticky flags {underflow, overflow}.

Function
REQ-022 SHALL update pc only on rising clk; all targets computed from current pc in the same cycle.
REQ-023 SHALL select next pc by priority: rst > stall > jr > ret > taken branch > jump/jal > pc_plus4.
REQ-024 SHALL define taken branch as (branch_eq & zero) | (branch_ne & ~zero).
REQ-025 SHALL compute branch target = pc_plus4 + (sign-extend(imm16) << 2), modulo 2^WIDTH.
REQ-026 SHALL compute jump target = {pc_plus4[WIDTH-1:28], imm26, 2'b00}.
REQ-027 SHALL on jal push pc_plus4 onto RAS, whether or not jal is the winning redirect.
REQ-028 SHALL on ret with RAS non-empty pop top and load it into pc.
REQ-029 SHALL on ret with RAS empty load jr_target, leave RAS unchanged, set ras_err[1].
REQ-030 SHALL on push while full overwrite the oldest entry (circular), keep count at RAS_DEPTH, set ras_err[0].
REQ-031 SHALL on jal and ret in the same cycle pop then push: pc = old top, top replaced by pc_plus4, count unchanged.
REQ-032 SHALL ignore jal push and ret pop when jr or stall is asserted.
REQ-033 SHALL keep ras_err bits set until rst.
REQ-034 SHALL drive ras_empty/ras_full from registered count, no combinational path from inputs.

Reset
REQ-035 SHALL on rst load pc = RESET_PC, RAS count = 0, pointer = 0, ras_err = 0; entries need not clear.
REQ-036 SHALL let rst override stall and all redirects in the same cycle, including mid-push/pop.
REQ-037 SHALL after rst deassert advance to RESET_PC+4 on the first unstalled edge.

Structure
REQ-038 SHALL place the next-pc select encoding and the constant 4 byte-step in shared package cpu_pkg.
REQ-039 SHALL implement the stack as sub-module ras_stack (push, pop, top, count, empty, full, overflow).
REQ-040 SHALL contain no latches; all state in clk-edge flops.

Verification
REQ-041 SHALL test: rst, then 3 free cycles -> pc = 0, 4, 8, 12.
REQ-042 SHALL test: pc=0x10, branch_eq=1, zero=1, imm16=0xFFFE -> pc=0x0C; zero=0 -> pc=0x14.
REQ-043 SHALL test: pc=0x40000010, jump=1, imm26=0x10 -> pc=0x40000040.
REQ-044 SHALL test: jal at pc=0x100, then ret at pc=0x200 -> pc=0x104, ras_empty=1.
REQ-045 SHALL test: RAS_DEPTH=4, 5 jals then 5 rets with jr_target=0xDEAD0000 -> last 4 rets return to the newest 4 addresses, 5th goes to 0xDEAD0000, ras_err=2'b11.
REQ-046 SHALL test: stall=1 with jal=1 -> pc and count unchanged; rst during stall -> pc=RESET_PC.
